ddr_arbiter: RTL and testbench
==============================

DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, which sets the busy-cycle count (1..65535) at which timeout_err sets.
REQ-002 SHALL have port clk, input, 1, the single clock (the DDR user-interface clock); all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: one clock, reset synchronous and active-low.
REQ-004 SHALL have ic_req/ic_write/ic_addr/ic_wdata as inputs of width 1/1/30/256: instruction-side request, write flag, 4-byte-aligned word address and block data.
REQ-005 SHALL have ic_ack (output, 1) as the one-cycle completion pulse, and ic_rdata (output, 256) as the read block, held until the next ic completion.
REQ-006 SHALL have dc_req, dc_write, dc_addr, dc_wdata, dc_ack and dc_rdata with the same widths and meanings for the data side.
REQ-007 SHALL have ram_en/ram_write/ram_addr/data_to_ram as outputs of width 1/1/30/256 that drive the DDR controller command.
REQ-008 SHALL have ram_rdy (input, 1), the DDR controller ready; it is combinational and low while the controller is busy.
REQ-009 SHALL have block_out (input, 256), the DDR controller read block.
REQ-010 SHALL have timeout_err (output, 1), a sticky flag.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY and ACK.
REQ-012 SHALL make all outputs registered, with no combinational path from input to output.
REQ-013 IDLE: SHALL select a requester if ic_req or dc_req is 1, load ram_* from the winner's ports, set ram_en=1 and go to BUSY.
- If no request is present, the FSM stays in IDLE.
REQ-014 Arbitration: SHALL grant directly when only one requester is active.
- When both are active, the grant goes to the port not granted last (round-robin).
- last_grant resets to ic, so dc wins the first tie.
REQ-015 BUSY: SHALL hold ram_en, ram_write, ram_addr and data_to_ram stable throughout; requester input changes are ignored.
REQ-016 BUSY: SHALL ignore ram_rdy in the first BUSY cycle (guard cycle).
- From the second cycle on, ram_rdy=1 captures block_out into the granted port's rdata (reads only), clears ram_en and moves to ACK.
REQ-017 ACK: SHALL assert the granted port's ack for exactly one cycle, then return to IDLE.
- Requests sampled during ACK are ignored.
REQ-018 Minimum latency, req sampled at edge T: BUSY at T+1, ram_rdy sampled at T+2 at the earliest, ack high during cycle T+3.
- Back-to-back grants are separated by at least one IDLE cycle.
REQ-019 Requester contract: req and its payload stay stable until ack is seen.
- The requester drops req in the cycle after ack.
- A request asserted while the other port is being served is held pending and must not be lost.
REQ-020 On a write completion, the port's rdata SHALL stay unchanged.
REQ-021 The other port's ack and rdata SHALL never change during a grant.
REQ-022 SHALL use a 16-bit counter that clears on entry to BUSY and increments each BUSY cycle, saturating at 65535.
- When it equals TIMEOUT_CYCLES, timeout_err is set and stays 1 until reset.
- The transaction is not aborted.
REQ-023 Simultaneous ram_rdy=1 on the cycle the counter reaches TIMEOUT_CYCLES: SHALL complete normally and still set timeout_err.

Reset
REQ-024 With rst_n=0 at a clock edge, the state SHALL be IDLE and ram_en=0, ram_write=0, ram_addr=0, data_to_ram=0.
REQ-025 Reset SHALL also clear ic_ack, dc_ack, ic_rdata, dc_rdata, timeout_err, the counter, and set last_grant=ic.
REQ-026 Reset during BUSY or ACK SHALL abandon the transaction and drop ram_en at that edge, with no ack issued.
REQ-027 No request SHALL be granted in the cycle rst_n=0.

Verification
REQ-028 Single read: dc_req=1, dc_addr=30'h100, dc_write=0; ram_rdy=1 from the second BUSY cycle with block_out=256'hA5.. -> ram_en 2 cycles, dc_ack one pulse at T+3, dc_rdata=256'hA5.., ic_ack never high.
REQ-029 Tie: ic_req and dc_req both raised at T with ram_rdy always 1 -> dc acked first, then ic; each ack a single pulse; the next tie goes to dc.
REQ-030 Write hold: ic write, addr=30'h40, ram_rdy low 20 cycles -> ram_en, ram_write=1, ram_addr=30'h40 and data_to_ram all stable for 21+ cycles, ic_ack once, ic_rdata unchanged.
REQ-031 Guard: ram_rdy held 1 throughout a request -> completion is not sampled in the first BUSY cycle; ack appears at T+3, not T+2.
REQ-032 Timeout: TIMEOUT_CYCLES=8, ram_rdy low 12 cycles -> timeout_err rises in the 8th BUSY cycle, transaction completes at ram_rdy, timeout_err stays 1 until rst_n=0.
REQ-033 Reset mid-op: rst_n=0 in the third BUSY cycle -> next cycle ram_en=0, state IDLE, no ack; a pending dc_req is granted after rst_n=1.

Source files
------------

// File: rtl/ddr_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a DDR user
// interface. One transaction in flight; all outputs come straight from flops.
module ddr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_req,
  input  logic         ic_write,
  input  logic [29:0]  ic_addr,
  input  logic [255:0] ic_wdata,
  output logic         ic_ack,
  output logic [255:0] ic_rdata,
  input  logic         dc_req,
  input  logic         dc_write,
  input  logic [29:0]  dc_addr,
  input  logic [255:0] dc_wdata,
  output logic         dc_ack,
  output logic [255:0] dc_rdata,
  output logic         ram_en,
  output logic         ram_write,
  output logic [29:0]  ram_addr,
  output logic [255:0] data_to_ram,
  input  logic         ram_rdy,
  input  logic [255:0] block_out,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t         state_q, state_d;
  logic           gnt_dc_q, gnt_dc_d;    // port currently being served
  logic           last_dc_q, last_dc_d;  // port granted last (0 = ic)
  logic [15:0]    cnt_q, cnt_d;
  logic           ram_en_q, ram_en_d;
  logic           ram_write_q, ram_write_d;
  logic [29:0]    ram_addr_q, ram_addr_d;
  logic [255:0]   data_to_ram_q, data_to_ram_d;
  logic           ic_ack_q, ic_ack_d;
  logic           dc_ack_q, dc_ack_d;
  logic [255:0]   ic_rdata_q, ic_rdata_d;
  logic [255:0]   dc_rdata_q, dc_rdata_d;
  logic           timeout_err_q, timeout_err_d;
  logic           pick_dc;

  // Next-state, arbitration and command/response updates
  always_comb begin
    state_d       = state_q;
    gnt_dc_d      = gnt_dc_q;
    last_dc_d     = last_dc_q;
    cnt_d         = cnt_q;
    ram_en_d      = ram_en_q;
    ram_write_d   = ram_write_q;
    ram_addr_d    = ram_addr_q;
    data_to_ram_d = data_to_ram_q;
    ic_ack_d      = 1'b0;
    dc_ack_d      = 1'b0;
    ic_rdata_d    = ic_rdata_q;
    dc_rdata_d    = dc_rdata_q;
    timeout_err_d = timeout_err_q;
    // dc wins when alone, or on a tie when ic was granted last
    pick_dc       = dc_req && (!ic_req || !last_dc_q);
    unique case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          gnt_dc_d      = pick_dc;
          last_dc_d     = pick_dc;
          ram_en_d      = 1'b1;
          ram_write_d   = pick_dc ? dc_write : ic_write;
          ram_addr_d    = pick_dc ? dc_addr  : ic_addr;
          data_to_ram_d = pick_dc ? dc_wdata : ic_wdata;
          cnt_d         = 16'd0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (cnt_d == TO_LIMIT) timeout_err_d = 1'b1;
        // cnt_q == 0 marks the guard cycle where ram_rdy is still stale
        if (cnt_q != 16'd0 && ram_rdy) begin
          ram_en_d = 1'b0;
          if (gnt_dc_q) begin
            dc_ack_d = 1'b1;
            if (!ram_write_q) dc_rdata_d = block_out;
          end else begin
            ic_ack_d = 1'b1;
            if (!ram_write_q) ic_rdata_d = block_out;
          end
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_dc_q      <= 1'b0;
      last_dc_q     <= 1'b0;
      cnt_q         <= 16'd0;
      ram_en_q      <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_addr_q    <= 30'd0;
      data_to_ram_q <= 256'd0;
      ic_ack_q      <= 1'b0;
      dc_ack_q      <= 1'b0;
      ic_rdata_q    <= 256'd0;
      dc_rdata_q    <= 256'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_dc_q      <= gnt_dc_d;
      last_dc_q     <= last_dc_d;
      cnt_q         <= cnt_d;
      ram_en_q      <= ram_en_d;
      ram_write_q   <= ram_write_d;
      ram_addr_q    <= ram_addr_d;
      data_to_ram_q <= data_to_ram_d;
      ic_ack_q      <= ic_ack_d;
      dc_ack_q      <= dc_ack_d;
      ic_rdata_q    <= ic_rdata_d;
      dc_rdata_q    <= dc_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_write   = ram_write_q;
  assign ram_addr    = ram_addr_q;
  assign data_to_ram = data_to_ram_q;
  assign ic_ack      = ic_ack_q;
  assign dc_ack      = dc_ack_q;
  assign ic_rdata    = ic_rdata_q;
  assign dc_rdata    = dc_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: table of single transactions plus
// hand-written tie, reset-mid-op and timeout sequences.
module tb_ddr_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, ic_write, dc_req, dc_write;
  logic [29:0]  ic_addr, dc_addr;
  logic [255:0] ic_wdata, dc_wdata;
  logic         ic_ack, dc_ack;
  logic [255:0] ic_rdata, dc_rdata;
  logic         ram_en, ram_write, ram_rdy;
  logic [29:0]  ram_addr;
  logic [255:0] data_to_ram, block_out;
  logic         timeout_err;

  int total = 0;
  int bad   = 0;

  // bench-side model of the response side
  logic [255:0] exp_ic_rd, exp_dc_rd;
  logic         to_exp;

  typedef struct {
    bit           is_dc;
    bit           wr;
    logic [29:0]  addr;
    logic [255:0] wdata;
    logic [255:0] blk;
    int           low;        // BUSY cycles with ram_rdy low
    logic [255:0] exp_rdata;  // requester rdata after completion
  } vec_t;

  vec_t tbl [5];

  ddr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_write(ic_write), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
    .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr),
    .data_to_ram(data_to_ram), .ram_rdy(ram_rdy), .block_out(block_out),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    ic_req = 0; dc_req = 0; ram_rdy = 0;
    rst_n = 0;
    tick; tick;
    rst_n = 1;
    exp_ic_rd = '0; exp_dc_rd = '0; to_exp = 0;
  endtask

  // One full transaction on one port; checks command hold, guard cycle,
  // ack timing/width, rdata update and the timeout flag cycle by cycle.
  task automatic run_txn(input vec_t v);
    int kd;
    if (v.is_dc) begin
      dc_req = 1; dc_write = v.wr; dc_addr = v.addr; dc_wdata = v.wdata;
    end else begin
      ic_req = 1; ic_write = v.wr; ic_addr = v.addr; ic_wdata = v.wdata;
    end
    block_out = v.blk;
    ram_rdy   = (v.low == 0);
    kd = (v.low + 1 < 2) ? 2 : v.low + 1;
    tick;  // request sampled, now in BUSY cycle 1
    for (int k = 1; k <= kd; k++) begin
      ram_rdy = (k > v.low);
      chk("busy_ram_en", ram_en, 1);
      chk("busy_ram_write", ram_write, v.wr);
      chk("busy_ram_addr", ram_addr, v.addr);
      chk("busy_data_to_ram", data_to_ram, v.wdata);
      chk("busy_ic_ack", ic_ack, 0);
      chk("busy_dc_ack", dc_ack, 0);
      chk("busy_timeout", timeout_err, to_exp);
      tick;
      if (k == TO) to_exp = 1;
    end
    if (v.is_dc) exp_dc_rd = v.exp_rdata; else exp_ic_rd = v.exp_rdata;
    chk("done_own_ack", v.is_dc ? dc_ack : ic_ack, 1);
    chk("done_other_ack", v.is_dc ? ic_ack : dc_ack, 0);
    chk("done_ram_en", ram_en, 0);
    chk("done_ic_rdata", ic_rdata, exp_ic_rd);
    chk("done_dc_rdata", dc_rdata, exp_dc_rd);
    chk("done_timeout", timeout_err, to_exp);
    tick;  // ACK -> IDLE; requester drops req now
    chk("ack_pulse_ic", ic_ack, 0);
    chk("ack_pulse_dc", dc_ack, 0);
    ic_req = 0; dc_req = 0; ram_rdy = 0;
    tick;
    chk("idle_ram_en", ram_en, 0);
  endtask

  initial begin
    tbl[0] = '{1, 0, 30'h100, 256'h0, {32{8'hA5}}, 1, {32{8'hA5}}};
    tbl[1] = '{0, 0, 30'h40, {8{32'h11112222}}, {8{32'hDEADBEEF}}, 0, {8{32'hDEADBEEF}}};
    tbl[2] = '{1, 1, 30'h120, {8{32'h12345678}}, {8{32'h0BAD0BAD}}, 3, {32{8'hA5}}};
    tbl[3] = '{0, 0, 30'h3FFFFFFF, 256'h0, {8{32'hCAFEF00D}}, 5, {8{32'hCAFEF00D}}};
    tbl[4] = '{0, 1, 30'h40, {8{32'h5A5A0001}}, {8{32'h77778888}}, 20, {8{32'hCAFEF00D}}};

    ic_req = 0; ic_write = 0; ic_addr = '0; ic_wdata = '0;
    dc_req = 0; dc_write = 0; dc_addr = '0; dc_wdata = '0;
    ram_rdy = 0; block_out = '0;

    // reset state
    do_reset;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_data_to_ram", data_to_ram, 0);
    chk("rst_ic_ack", ic_ack, 0);
    chk("rst_dc_ack", dc_ack, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    chk("rst_timeout", timeout_err, 0);

    // tie right after reset: dc first, then ic, next tie dc again
    ic_addr = 30'h200; ic_write = 0; dc_addr = 30'h300; dc_write = 0;
    ram_rdy = 1; block_out = {8{32'h01020304}};
    ic_req = 1; dc_req = 1;
    tick;
    chk("tie1_addr", ram_addr, 30'h300);
    tick;
    chk("tie1_guard_ack", dc_ack, 0);
    tick;
    chk("tie1_dc_ack", dc_ack, 1);
    chk("tie1_ic_ack", ic_ack, 0);
    tick;
    chk("tie1_dc_pulse", dc_ack, 0);
    dc_req = 0;
    tick;
    chk("tie2_ram_en", ram_en, 1);
    chk("tie2_addr", ram_addr, 30'h200);
    tick;
    chk("tie2_guard_ack", ic_ack, 0);
    tick;
    chk("tie2_ic_ack", ic_ack, 1);
    chk("tie2_dc_ack", dc_ack, 0);
    tick;
    chk("tie2_ic_pulse", ic_ack, 0);
    ic_req = 0;
    tick;
    ic_req = 1; dc_req = 1;
    tick;
    chk("tie3_addr", ram_addr, 30'h300);

    // table of single transactions
    do_reset;
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // reset in third BUSY cycle with dc request pending
    do_reset;
    ic_req = 1; ic_write = 0; ic_addr = 30'h80;
    tick;
    dc_req = 1; dc_write = 0; dc_addr = 30'h90; block_out = {8{32'h99990000}};
    tick; tick;
    rst_n = 0;
    tick;
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_ic_ack", ic_ack, 0);
    tick;
    chk("rstlow_no_grant", ram_en, 0);
    ic_req = 0; rst_n = 1;
    tick;
    chk("post_rst_ram_en", ram_en, 1);
    chk("post_rst_addr", ram_addr, 30'h90);
    ram_rdy = 1;
    tick; tick;
    chk("post_rst_dc_ack", dc_ack, 1);
    chk("post_rst_dc_rdata", dc_rdata, {8{32'h99990000}});
    chk("post_rst_ic_ack", ic_ack, 0);
    tick;
    dc_req = 0;

    // completion on the same edge the counter hits the limit
    do_reset;
    run_txn('{1, 0, 30'h55, 256'h0, {8{32'hABCD0123}}, TO - 1, {8{32'hABCD0123}}});

    // timeout while waiting, sticky until reset
    do_reset;
    run_txn('{0, 0, 30'h66, 256'h0, {8{32'h31415926}}, 12, {8{32'h31415926}}});
    tick; tick; tick;
    chk("timeout_sticky", timeout_err, 1);
    do_reset;
    chk("timeout_cleared", timeout_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
